// File: rtl/div3_pkg.sv
// Shared definitions for the divide-by-3 sharing arbiter.
// The round-robin helper scans the requester mask starting at the pointer.
package div3_pkg;

    localparam int DATA_W    = 32;
    localparam int N_REQ_DEF = 4;
    localparam int MAX_REQ   = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of mask among n entries, scanning ptr, ptr+1, ... with wrap.
    function automatic rr_pick_t rr_first(input logic [MAX_REQ-1:0] mask,
                                          input logic [3:0]         ptr,
                                          input int unsigned        n);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !r.found && mask[j[3:0]]) begin
                r.found = 1'b1;
                r.idx   = j[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/div3_rr_pick.sv
// Round-robin picker: eligibility mask plus pointer gives a one-hot grant and its index.
module div3_rr_pick
    import div3_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             found
);

    rr_pick_t pick;

    always_comb begin
        pick      = rr_first(MAX_REQ'(elig), 4'(ptr), N_REQ);
        found     = pick.found;
        grant_idx = ID_W'(pick.idx);
        grant     = pick.found ? (N_REQ'(1) << pick.idx) : '0;
    end

endmodule

// File: rtl/test_div_3.sv
// Combinational divisibility-by-3 test of an unsigned 32-bit operand.
module test_div_3 (
    input  logic [31:0] in,
    output logic        out
);

    assign out = ((in % 32'd3) == 32'd0);

endmodule

// File: rtl/div3_share_arbiter.sv
// Shares one test_div_3 among N_REQ requesters: round-robin grant, one-cycle
// operand stage, then a per-requester result slot released by acknowledge.
module div3_share_arbiter
    import div3_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [N_REQ-1:0]        rsp_divisible,
    input  logic [N_REQ-1:0]        rsp_ack,
    output logic                    busy,
    output logic [CNT_W-1:0]        accepted_cnt
);

    logic              op_valid;
    logic [ID_W-1:0]   op_id;
    logic [DATA_W-1:0] op_data;
    logic [ID_W-1:0]   ptr;
    logic [N_REQ-1:0]  elig;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic              div_out;

    // A requester with a full slot or an operand in flight cannot be granted again.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] & ~rsp_valid[i] & ~(op_valid && (op_id == ID_W'(i)));
        end
    end

    div3_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .elig      (elig),
        .ptr       (ptr),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .found     (grant_found)
    );

    test_div_3 u_div (
        .in  (op_data),
        .out (div_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid      <= 1'b0;
            op_id         <= '0;
            op_data       <= '0;
            ptr           <= '0;
            accepted_cnt  <= '0;
            rsp_valid     <= '0;
            rsp_divisible <= '0;
        end else begin
            if (grant_found) begin
                op_valid     <= 1'b1;
                op_id        <= grant_idx;
                op_data      <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                ptr          <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                accepted_cnt <= accepted_cnt + 1'b1;
            end else begin
                op_valid <= 1'b0;
            end

            for (int i = 0; i < N_REQ; i++) begin
                if (rsp_ack[i] && rsp_valid[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
            // Slot op_id is empty by eligibility, so this write never collides with an ack.
            if (op_valid) begin
                rsp_valid[op_id]     <= 1'b1;
                rsp_divisible[op_id] <= div_out;
            end
        end
    end

    assign busy = op_valid;

endmodule

// File: tb/tb_div3_share_arbiter.sv
// Self-checking bench for div3_share_arbiter against a transaction-level model
// of slots, in-flight operand, round-robin pointer and accepted count.
module tb_div3_share_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_divisible;
    logic [N-1:0]    rsp_ack;
    logic            busy;
    logic [15:0]     accepted_cnt;

    div3_share_arbiter #(.N_REQ(N), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_divisible (rsp_divisible),
        .rsp_ack       (rsp_ack),
        .busy          (busy),
        .accepted_cnt  (accepted_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit          m_full [N];
    bit          m_div  [N];
    bit          m_inflight;
    int          m_id;
    logic [31:0] m_data;
    int          m_ptr;
    int          m_cnt;
    int          n_xfer;
    logic [31:0] d_arr  [N];
    logic [N-1:0] last_ready;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (v[idx] && !m_full[idx] && !(m_inflight && m_id == idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_div[i]  = 1'b0;
        end
        m_inflight = 1'b0;
        m_id       = 0;
        m_data     = '0;
        m_ptr      = 0;
        m_cnt      = 0;
        n_xfer     = 0;
    endtask

    task automatic check_state();
        logic [N-1:0] ev, ed;
        for (int i = 0; i < N; i++) begin
            ev[i] = m_full[i];
            ed[i] = m_div[i];
        end
        check_val("rsp_valid", 32'(rsp_valid), 32'(ev));
        check_val("rsp_divisible", 32'(rsp_divisible & ev), 32'(ed & ev));
        check_val("busy", 32'(busy), 32'(m_inflight));
        check_val("accepted_cnt", 32'(accepted_cnt), 32'(m_cnt));
    endtask

    // Drive one cycle (entered and left at posedge+1), check grant, advance model.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] ack);
        int g;
        req_valid = v;
        rsp_ack   = ack;
        for (int i = 0; i < N; i++) req_data[i*32 +: 32] = d_arr[i];
        #1;
        g = model_grant(v);
        check_val("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        last_ready = req_ready;
        @(posedge clk);
        for (int i = 0; i < N; i++) if (ack[i] && m_full[i]) m_full[i] = 1'b0;
        if (m_inflight) begin
            m_full[m_id] = 1'b1;
            m_div[m_id]  = ((m_data % 3) == 0);
        end
        if (g >= 0) begin
            m_inflight = 1'b1;
            m_id       = g;
            m_data     = d_arr[g];
            m_ptr      = (g + 1) % N;
            m_cnt      = (m_cnt + 1) % 65536;
            n_xfer++;
        end else begin
            m_inflight = 1'b0;
        end
        #1;
        check_state();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ack   = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_state();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'hFFFF_FFFE;
            2:       return 32'h0000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ack   = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) d_arr[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_state();
        check_val("reset_ready", 32'(req_ready), 32'd0);

        // Single divisible request on requester 0.
        d_arr[0] = 32'hFFFF_FFFF;
        cycle(4'b0001, 4'b0000);
        check_val("t1_grant", 32'(last_ready), 32'h1);
        cycle(4'b0000, 4'b0000);
        check_val("t1_valid", 32'(rsp_valid[0]), 32'd1);
        check_val("t1_div", 32'(rsp_divisible[0]), 32'd1);
        check_val("t1_cnt", 32'(accepted_cnt), 32'd1);
        cycle(4'b0000, 4'b0001);

        // Non-multiple, then zero, on requester 2.
        d_arr[2] = 32'hFFFF_FFFE;
        cycle(4'b0100, 4'b0000);
        cycle(4'b0000, 4'b0000);
        check_val("t2_div_fffffffe", 32'(rsp_divisible[2]), 32'd0);
        cycle(4'b0000, 4'b0100);
        d_arr[2] = 32'h0;
        cycle(4'b0100, 4'b0000);
        cycle(4'b0000, 4'b0000);
        check_val("t2_div_zero", 32'(rsp_divisible[2]), 32'd1);
        cycle(4'b0000, 4'b0100);

        // Fairness: everyone valid, everyone acks immediately.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) d_arr[i] = rand_operand();
            cycle(4'b1111, 4'b1111);
            check_val("fair_seq", 32'(last_ready), 32'd1 << (k % N));
            check_val("fair_busy", 32'(busy), 32'd1);
        end

        // Requester 1 never acks: it must stay blocked while others proceed.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) d_arr[i] = rand_operand();
            cycle(4'(($urandom & 4'b1101) | 4'b0010), 4'($urandom & 4'b1101));
            if (k >= 2) check_val("blk_ready1", 32'(last_ready[1]), 32'd0);
        end
        cycle(4'b0010, 4'b0010);
        check_val("blk_ack_cycle", 32'(last_ready[1]), 32'd0);
        cycle(4'b0010, 4'b0000);
        check_val("blk_after_ack", 32'(last_ready[1]), 32'd1);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) d_arr[i] = rand_operand();
            cycle(4'($urandom), 4'($urandom));
        end

        // Reset while an operand is in flight.
        do_reset();
        cycle(4'b0001, 4'b1111);
        d_arr[3] = 32'd9;
        cycle(4'b1000, 4'b0000);
        check_val("mid_busy_pre", 32'(busy), 32'd1);
        do_reset();
        check_val("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("mid_busy", 32'(busy), 32'd0);
        check_val("mid_cnt", 32'(accepted_cnt), 32'd0);
        cycle(4'b1111, 4'b0000);
        check_val("mid_first_grant", 32'(last_ready), 32'h1);
        cycle(4'b0000, 4'b0000);
        check_val("mid_no_stale3", 32'(rsp_valid[3]), 32'd0);

        // Counter wrap with an operand sweep near the top of the range.
        do_reset();
        cyc = 0;
        while (n_xfer < 65536 && cyc < 80000) begin
            for (int i = 0; i < N; i++)
                d_arr[i] = 32'hFFFF_FFFF - 32'd100000 + 32'((cyc * 3) / 2) + 32'(i);
            if (cyc == 20) d_arr[0] = 32'hFFFF_FFFF;
            cycle(4'b1111, 4'b1111);
            cyc++;
        end
        check_val("wrap_done", 32'(n_xfer), 32'd65536);
        check_val("wrap_cnt", 32'(accepted_cnt), 32'd0);
        cycle(4'b0000, 4'b1111);
        cycle(4'b0000, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div3_share_arbiter.md
Name: div3_share_arbiter

Overview:
Shares one combinational divisibility-by-3 unit (existing test_div_3, 32-bit `in`, 1-bit `out`) among N_REQ requesters. The unit is shared by round-robin arbitration with a valid/ready request handshake. Each requester has one result slot that it releases with an acknowledge. The block sits between requesting engines and the single test_div_3 instance, and owns all sequencing of that instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, $clog2(N_REQ), width of requester index
CNT_W, 16, width of accepted-request counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request valid
req_data  in  N_REQ*32  per-requester operand; requester i uses bits [32*i+31:32*i]
req_ready  out  N_REQ  grant; transfer on req_valid[i] & req_ready[i]
rsp_valid  out  N_REQ  result slot i full
rsp_divisible  out  N_REQ  result i: 1 = operand % 3 == 0
rsp_ack  in  N_REQ  requester i consumes its result; ignored when rsp_valid[i]=0
busy  out  1  operand stage occupied
accepted_cnt  out  CNT_W  total accepted requests, wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous): rsp_valid=0, rsp_divisible=0, busy=0, accepted_cnt=0, rr pointer ptr=0, op_valid=0.
- Reset while a request is in flight: the in-flight operand is discarded and no response is produced.
- Eligibility of requester i:
  - req_valid[i] & ~rsp_valid[i] & ~(op_valid & op_id==i).
  - An un-acked slot or an in-flight op blocks new requests from that requester.
- Arbitration:
  - Combinational, one grant per cycle.
  - The first eligible index scanning ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 wins.
  - req_ready is one-hot or zero.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Operand stage:
  - On a transfer, at the edge: op_data<=req_data slice, op_id<=i, op_valid<=1, ptr<=(i+1) mod N_REQ, accepted_cnt<=accepted_cnt+1.
  - With no transfer: op_valid<=0 and ptr is held.
- Result stage:
  - When op_valid=1, at the edge: rsp_valid[op_id]<=1, rsp_divisible[op_id]<=test_div_3(op_data).out.
  - The stage never stalls, because the slot is guaranteed empty by eligibility.
- Latency and throughput:
  - A request transferred at edge E gives rsp_valid high after edge E+1.
  - Aggregate throughput is 1 request/cycle across different requesters.
  - A single requester can issue at most once per 3 cycles: transfer, result, ack.
- Acknowledge: rsp_ack[i] & rsp_valid[i] clears rsp_valid[i] at the edge. rsp_divisible[i] holds its value (don't-care once rsp_valid[i] is low).
- Simultaneous ack of slot i and a request from i: slot i is not eligible in that cycle. The grant can occur the following cycle at the earliest.
- busy = op_valid.
- accepted_cnt wraps 0xFFFF -> 0x0000 silently.
- Arithmetic:
  - The operand is an unsigned 32-bit value.
  - 0 and 0xFFFFFFFF are divisible; 0xFFFFFFFE is not.
- req_data of non-granted requesters is ignored.

Decomposition:
- Shared package div3_pkg holds:
  - DATA_W=32
  - the default N_REQ
  - the function rr_first(mask, ptr) returning the index and a found flag
- Sub-module div3_rr_pick (eligibility mask + ptr -> one-hot grant, index) is natural and separately testable.
- test_div_3 is instantiated exactly once, unchanged.

Test Plan:
- Single request, N_REQ=4: after reset, req0 data=0xFFFFFFFF -> granted in the same cycle; rsp_valid[0]=1 next edge with rsp_divisible[0]=1; accepted_cnt=1.
- Non-multiple: req2 data=0xFFFFFFFE -> rsp_divisible[2]=0. Then ack, then data=0 -> rsp_divisible[2]=1.
- Fairness: all four requesters assert valid continuously after reset and ack immediately:
  - grants run 0,1,2,3,0,… with no requester granted twice before the others.
  - busy stays 1 from the first transfer.
- Blocking slot: req1 keeps valid high without acking -> req_ready[1] stays 0 while others proceed. After rsp_ack[1], req1 is granted no earlier than the following cycle.
- Reset mid-flight: transfer on req3, assert rst on the next cycle -> rsp_valid stays 0, busy=0, accepted_cnt=0, ptr back to 0 (a subsequent all-valid round grants req0 first).
- Counter wrap: force 65536 accepted transfers -> accepted_cnt returns to 0x0000 with correct results throughout. Check with a sweep across 0xFFFFFFFF-100000..0xFFFFFFFF against a model of operand%3.
